// File: rtl/imem_loader_if.sv
// Instruction-load bus between a word source and the loader, plus the
// instruction SRAM write port driven by the loader.
//   in_valid/in_data/in_last : source -> loader word stream
//   in_ready                 : loader -> source, word accepted this cycle
//   mem_cs/mem_we/mem_addr/mem_din : loader -> instruction SRAM write port
// Modport slave is the loader side; modport master is the source/memory side.
interface imem_loader_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;

    logic              mem_cs;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, mem_cs, mem_we, mem_addr, mem_din
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, mem_cs, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: accepts a stream of instruction words and writes
// them to consecutive word addresses of the instruction SRAM starting at
// BASE_ADDR, keeping a word count and a modulo-2^32 checksum of the session.
// Ports:
//   clk         : clock, rising edge
//   areset      : asynchronous active-low reset
//   start       : begin a new load session (ignored while loading)
//   bus         : word stream in / SRAM write port out (imem_loader_if.slave)
//   busy        : load in progress (equals in_ready)
//   done        : last session ended on an in_last word
//   error       : last session overflowed MAX_WORDS
//   word_count  : words written in the current/last session
//   checksum    : sum of words written in the current/last session
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h00400020,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic                clk,
    input  logic                areset,
    input  logic                start,
    imem_loader_if.slave        bus,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [15:0]         word_count,
    output logic [31:0]         checksum
);
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t            state_q,      state_d;
    logic              in_ready_q,   in_ready_d;
    logic              mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0] mem_din_q,    mem_din_d;
    logic              done_q,       done_d;
    logic              error_q,      error_d;
    logic [CNT_W-1:0]  word_count_q, word_count_d;
    logic [DATA_W-1:0] checksum_q,   checksum_d;

    // State and output registers; reset also kills any write pending this cycle.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= BASE_ADDR;
            mem_din_q    <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            word_count_q <= '0;
            checksum_q   <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            done_q       <= done_d;
            error_q      <= error_d;
            word_count_q <= word_count_d;
            checksum_q   <= checksum_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        done_d       = done_q;
        error_d      = error_q;
        word_count_d = word_count_q;
        checksum_d   = checksum_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d      = LOAD;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    word_count_d = '0;
                    checksum_d   = '0;
                end
            end
            LOAD: begin
                if (bus.in_valid) begin
                    if (word_count_q < MAX_CNT) begin
                        // Address uses the pre-increment count; 32-bit wrap is allowed.
                        mem_we_d     = 1'b1;
                        mem_addr_d   = BASE_ADDR + {{(ADDR_W-CNT_W-2){1'b0}}, word_count_q, 2'b00};
                        mem_din_d    = bus.in_data;
                        word_count_d = word_count_q + CNT_W'(1);
                        checksum_d   = checksum_q + bus.in_data;
                        if (bus.in_last) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        // Overflow word is dropped: no write, counters untouched.
                        state_d = ERR;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == LOAD);
    end

    assign bus.in_ready = in_ready_q;
    assign bus.mem_cs   = mem_we_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
    assign busy         = in_ready_q;
    assign done         = done_q;
    assign error        = error_q;
    assign word_count   = word_count_q;
    assign checksum     = checksum_q;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a default instance (MAX_WORDS=1024) and
// a small instance (MAX_WORDS=2) for overflow, checked against a session-level
// reference model of expected SRAM writes, count and checksum.
module tb_imem_loader;
    localparam logic [31:0] BASE = 32'h00400020;
    localparam int unsigned MAX1 = 1024;
    localparam int unsigned MAX2 = 2;

    logic        clk = 1'b0;
    logic        areset, start, start2;
    logic        busy, done, error, busy2, done2, error2;
    logic [15:0] word_count, word_count2;
    logic [31:0] checksum, checksum2;

    int n_checks = 0;
    int n_fail   = 0;

    imem_loader_if bus ();
    imem_loader_if bus2 ();

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAX1)) dut (
        .clk(clk), .areset(areset), .start(start), .bus(bus),
        .busy(busy), .done(done), .error(error),
        .word_count(word_count), .checksum(checksum)
    );

    imem_loader #(.MAX_WORDS(MAX2)) dut2 (
        .clk(clk), .areset(areset), .start(start2), .bus(bus2),
        .busy(busy2), .done(done2), .error(error2),
        .word_count(word_count2), .checksum(checksum2)
    );

    always #5 clk = ~clk;

    // Observed SRAM writes, sampled on the falling edge.
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic        obs_done[$];
    logic [31:0] obs2_addr[$];
    logic [31:0] obs2_data[$];
    int          stray_strobe = 0;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            obs_addr.push_back(bus.mem_addr);
            obs_data.push_back(bus.mem_din);
            obs_done.push_back(done);
        end
        if (bus2.mem_we === 1'b1) begin
            obs2_addr.push_back(bus2.mem_addr);
            obs2_data.push_back(bus2.mem_din);
        end
        if ((bus.mem_cs === 1'b1 || bus.mem_we === 1'b1) && bus.mem_cs !== bus.mem_we)
            stray_strobe++;
        if ((bus2.mem_cs === 1'b1 || bus2.mem_we === 1'b1) && bus2.mem_cs !== bus2.mem_we)
            stray_strobe++;
    end

    // Reference model: a session writes words to BASE+4*n until in_last or MAX.
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int unsigned m_cnt;
    logic [31:0] m_sum;
    bit          m_load, m_done, m_err;

    task automatic model_reset();
        m_load = 0; m_done = 0; m_err = 0; m_cnt = 0; m_sum = '0;
    endtask

    task automatic model_start();
        if (!m_load) begin
            m_load = 1; m_done = 0; m_err = 0; m_cnt = 0; m_sum = '0;
        end
    endtask

    task automatic model_word(input logic [31:0] d, input bit last, input int unsigned max);
        if (!m_load) return;
        if (m_cnt < max) begin
            exp_addr.push_back(BASE + 32'(4 * m_cnt));
            exp_data.push_back(d);
            m_cnt++;
            m_sum = m_sum + d;
            if (last) begin m_load = 0; m_done = 1; end
        end else begin
            m_load = 0; m_err = 1;
        end
    endtask

    task automatic clear_q();
        obs_addr.delete(); obs_data.delete(); obs_done.delete();
        obs2_addr.delete(); obs2_data.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start();
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        model_start();
    endtask

    task automatic pulse_start2();
        start2 = 1'b1; @(posedge clk); #1; start2 = 1'b0;
        model_start();
    endtask

    task automatic send(input logic [31:0] d, input bit last);
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = last;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        model_word(d, last, MAX1);
    endtask

    task automatic send2(input logic [31:0] d, input bit last);
        bus2.in_valid = 1'b1; bus2.in_data = d; bus2.in_last = last;
        @(posedge clk); #1;
        bus2.in_valid = 1'b0; bus2.in_last = 1'b0;
        model_word(d, last, MAX2);
    endtask

    task automatic test_reset();
        @(posedge clk); #2;
        areset = 1'b0;
        model_reset();
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        n_checks++; if (bus.mem_cs !== 1'b0 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_strobes got cs=%b we=%b exp=0", bus.mem_cs, bus.mem_we); end
        n_checks++; if (bus.mem_addr !== BASE) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=%h", bus.mem_addr, BASE); end
        n_checks++; if (bus.mem_din !== 32'h0) begin n_fail++; $display("FAIL reset_mem_din got=%h exp=0", bus.mem_din); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL reset_flags got busy=%b done=%b error=%b exp=000", busy, done, error); end
        n_checks++; if (word_count !== 16'h0 || checksum !== 32'h0) begin n_fail++; $display("FAIL reset_counters got wc=%0d cs=%h exp=0", word_count, checksum); end
        n_checks++; if (bus2.mem_addr !== 32'h00400020 || busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_dut2 got addr=%h busy=%b exp=00400020/0", bus2.mem_addr, busy2); end
        @(negedge clk); areset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        clear_q();
        pulse_start();
        n_checks++; if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_busy got busy=%b ready=%b exp=1", busy, bus.in_ready); end
        send(32'h20020001, 1'b0);
        send(32'h8C010000, 1'b0);
        send(32'hAC020004, 1'b1);
        idle(2);
        n_checks++;
        if (obs_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL basic_nwrites got=%0d exp=%0d", obs_addr.size(), exp_addr.size()); end
        else foreach (exp_addr[i]) begin
            n_checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin n_fail++; $display("FAIL basic_write%0d got=%h:%h exp=%h:%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]); end
        end
        n_checks++; if (obs_done.size() != 3 || obs_done[0] !== 1'b0 || obs_done[2] !== 1'b1) begin n_fail++; $display("FAIL basic_done_timing got n=%0d exp done only with 3rd write", obs_done.size()); end
        n_checks++; if (word_count !== 16'd3) begin n_fail++; $display("FAIL basic_word_count got=%0d exp=3", word_count); end
        n_checks++; if (checksum !== 32'h58050005) begin n_fail++; $display("FAIL basic_checksum got=%h exp=58050005", checksum); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b1 || error !== 1'b0) begin n_fail++; $display("FAIL basic_flags got busy=%b done=%b error=%b exp=0/1/0", busy, done, error); end
        n_checks++; if (bus.mem_addr !== 32'h00400028 || bus.mem_din !== 32'hAC020004) begin n_fail++; $display("FAIL basic_hold got=%h:%h exp=00400028:ac020004", bus.mem_addr, bus.mem_din); end
    endtask

    task automatic test_gaps();
        clear_q();
        pulse_start();
        send(32'h20020001, 1'b0); idle(2);
        send(32'h8C010000, 1'b0); idle(2);
        send(32'hAC020004, 1'b1); idle(2);
        n_checks++;
        if (obs_addr.size() != 3) begin n_fail++; $display("FAIL gaps_nwrites got=%0d exp=3", obs_addr.size()); end
        else foreach (exp_addr[i]) begin
            n_checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin n_fail++; $display("FAIL gaps_write%0d got=%h:%h exp=%h:%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]); end
        end
        n_checks++; if (checksum !== 32'h58050005 || done !== 1'b1) begin n_fail++; $display("FAIL gaps_result got cs=%h done=%b exp=58050005/1", checksum, done); end
    endtask

    task automatic test_start_in_load();
        logic [31:0] d;
        clear_q();
        pulse_start();
        send($urandom, 1'b0);
        pulse_start();
        send($urandom, 1'b0);
        idle(1);
        n_checks++; if (word_count !== 16'(m_cnt) || checksum !== m_sum) begin n_fail++; $display("FAIL sil_counters got wc=%0d cs=%h exp=%0d/%h", word_count, checksum, m_cnt, m_sum); end
        n_checks++; if (bus.mem_addr !== BASE + 32'd4) begin n_fail++; $display("FAIL sil_mem_addr got=%h exp=%h", bus.mem_addr, BASE + 32'd4); end
        send($urandom, 1'b1);
        idle(1);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL sil_done got=%b exp=1", done); end
        pulse_start();
        n_checks++; if (done !== 1'b0 || busy !== 1'b1 || word_count !== 16'd0) begin n_fail++; $display("FAIL sil_restart got done=%b busy=%b wc=%0d exp=0/1/0", done, busy, word_count); end
        clear_q();
        d = $urandom;
        send(d, 1'b1);
        idle(2);
        n_checks++; if (obs_addr.size() != 1 || obs_addr[0] !== BASE || obs_data[0] !== d) begin n_fail++; $display("FAIL sil_first_write got n=%0d exp 1 write at %h", obs_addr.size(), BASE); end
    endtask

    task automatic test_overflow();
        clear_q();
        pulse_start2();
        send2($urandom, 1'b0);
        send2($urandom, 1'b0);
        n_checks++; if (error2 !== 1'b0 || busy2 !== 1'b1) begin n_fail++; $display("FAIL ovf_early got error=%b busy=%b exp=0/1", error2, busy2); end
        send2($urandom, 1'b0);
        idle(2);
        n_checks++;
        if (obs2_addr.size() != 2) begin n_fail++; $display("FAIL ovf_nwrites got=%0d exp=2", obs2_addr.size()); end
        else foreach (exp_addr[i]) begin
            n_checks++;
            if (obs2_addr[i] !== exp_addr[i] || obs2_data[i] !== exp_data[i]) begin n_fail++; $display("FAIL ovf_write%0d got=%h:%h exp=%h:%h", i, obs2_addr[i], obs2_data[i], exp_addr[i], exp_data[i]); end
        end
        n_checks++; if (error2 !== 1'b1 || done2 !== 1'b0 || busy2 !== 1'b0) begin n_fail++; $display("FAIL ovf_flags got error=%b done=%b busy=%b exp=1/0/0", error2, done2, busy2); end
        n_checks++; if (word_count2 !== 16'd2 || checksum2 !== m_sum) begin n_fail++; $display("FAIL ovf_counters got wc=%0d cs=%h exp=2/%h", word_count2, checksum2, m_sum); end
        foreach (obs2_addr[i]) begin
            n_checks++;
            if (obs2_addr[i] === 32'h00400028) begin n_fail++; $display("FAIL ovf_extra_write got write at %h exp none", obs2_addr[i]); end
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] d;
        clear_q();
        pulse_start();
        send($urandom, 1'b0);
        send($urandom, 1'b0);
        #1;
        areset = 1'b0;
        model_reset();
        // The second word's write would land in this cycle; reset drops it.
        void'(exp_addr.pop_back());
        void'(exp_data.pop_back());
        #1;
        n_checks++; if (bus.mem_we !== 1'b0 || busy !== 1'b0 || word_count !== 16'd0) begin n_fail++; $display("FAIL abort_reset got we=%b busy=%b wc=%0d exp=0/0/0", bus.mem_we, busy, word_count); end
        @(negedge clk); areset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (obs_addr.size() != 1 || obs_addr[0] !== exp_addr[0] || obs_data[0] !== exp_data[0]) begin n_fail++; $display("FAIL abort_writes got n=%0d exp 1 write before reset", obs_addr.size()); end
        clear_q();
        pulse_start();
        d = $urandom;
        send(d, 1'b1);
        idle(2);
        n_checks++; if (obs_addr.size() != 1 || obs_addr[0] !== 32'h00400020 || obs_data[0] !== d) begin n_fail++; $display("FAIL abort_reload got n=%0d exp 1 write at 00400020", obs_addr.size()); end
        n_checks++; if (word_count !== 16'd1 || checksum !== d || done !== 1'b1) begin n_fail++; $display("FAIL abort_result got wc=%0d cs=%h done=%b exp=1/%h/1", word_count, checksum, done, d); end
    endtask

    task automatic test_random();
        int n;
        for (int s = 0; s < 6; s++) begin
            clear_q();
            pulse_start();
            n = int'($urandom_range(1, 8));
            for (int i = 0; i < n; i++) begin
                send($urandom, i == n - 1);
                idle(int'($urandom_range(0, 3)));
            end
            idle(2);
            n_checks++;
            if (obs_addr.size() != exp_addr.size()) begin n_fail++; $display("FAIL rand%0d_nwrites got=%0d exp=%0d", s, obs_addr.size(), exp_addr.size()); end
            else foreach (exp_addr[i]) begin
                n_checks++;
                if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin n_fail++; $display("FAIL rand%0d_write%0d got=%h:%h exp=%h:%h", s, i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]); end
            end
            n_checks++; if (word_count !== 16'(m_cnt) || checksum !== m_sum) begin n_fail++; $display("FAIL rand%0d_counters got wc=%0d cs=%h exp=%0d/%h", s, word_count, checksum, m_cnt, m_sum); end
            n_checks++; if (done !== 1'(m_done) || busy !== 1'b0) begin n_fail++; $display("FAIL rand%0d_flags got done=%b busy=%b exp=%b/0", s, done, busy, m_done); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1; start = 1'b0; start2 = 1'b0;
        bus.in_valid = 1'b0;  bus.in_data = '0;  bus.in_last = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.in_last = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_gaps();
        test_start_in_load();
        test_overflow();
        test_reset_abort();
        test_random();
        n_checks++; if (stray_strobe != 0) begin n_fail++; $display("FAIL strobe_pairing got=%0d unmatched cs/we cycles exp=0", stray_strobe); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h00400020, giving the byte address of the first instruction word written.
REQ-002 The block SHALL have parameter MAX_WORDS, default 1024, giving the maximum number of words per load, in the range 1..65535.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port areset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: begin a new load session.
REQ-006 Port in_valid, input, 1 bit: in_data and in_last are valid.
REQ-007 Port in_data, input, 32 bits: instruction word.
REQ-008 Port in_last, input, 1 bit: the current word is the final word of the program.
REQ-009 Port in_ready, output, 1 bit: the loader accepts a word this cycle.
REQ-010 Port mem_cs, output, 1 bit: instruction SRAM chip select.
REQ-011 Port mem_we, output, 1 bit: instruction SRAM write strobe.
REQ-012 Port mem_addr, output, 32 bits: instruction SRAM byte address.
REQ-013 Port mem_din, output, 32 bits: instruction SRAM write data.
REQ-014 Port busy, output, 1 bit: a load is in progress; the fetch PC is held while busy.
REQ-015 Port done, output, 1 bit: the last load completed successfully.
REQ-016 Port error, output, 1 bit: the last load overflowed MAX_WORDS.
REQ-017 Port word_count, output, 16 bits: number of words written in the current or last session.
REQ-018 Port checksum, output, 32 bits: sum modulo 2^32 of all words written in the session.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, DONE and ERR.
REQ-020 start sampled high in IDLE, DONE or ERR SHALL move the FSM to LOAD on the next edge and, on that edge, clear word_count, checksum, done and error.
REQ-021 start SHALL be ignored while in LOAD.
REQ-022 in_ready SHALL be high exactly when the FSM is in LOAD; busy SHALL equal in_ready.
REQ-023 A word SHALL be accepted on any edge where in_valid and in_ready are both high; in_valid low SHALL cause no write and no state change.
REQ-024 An accepted word with word_count < MAX_WORDS SHALL be written with latency 1: in the following cycle mem_cs=1, mem_we=1, mem_addr=BASE_ADDR+4*word_count (the pre-increment value), mem_din=in_data.
REQ-025 On that same acceptance edge, word_count SHALL increment by 1 and checksum SHALL add in_data, with the carry discarded.
REQ-026 mem_we and mem_cs SHALL be single-cycle pulses, one per written word, and low otherwise.
REQ-027 mem_addr and mem_din SHALL hold their last values when no write is occurring.
REQ-028 Address arithmetic SHALL be 32-bit, with wrap-around past 32'hFFFFFFFC permitted and not flagged.
REQ-029 An accepted word with in_last=1 and word_count < MAX_WORDS SHALL be written and SHALL move the FSM to DONE on the acceptance edge.
REQ-030 In the above case, done SHALL assert in the same cycle as the final mem_we pulse.
REQ-031 An accepted word with word_count == MAX_WORDS SHALL NOT be written, regardless of in_last.
REQ-032 In the overflow case, the FSM SHALL move to ERR, error SHALL go to 1, and word_count and checksum SHALL be unchanged.
REQ-033 done SHALL remain high in DONE and error SHALL remain high in ERR until the next accepted start or a reset.
REQ-034 start and an accepted word can never coincide, since start is ignored in LOAD.

Reset
REQ-035 areset low SHALL immediately force state IDLE, in_ready=0, mem_cs=0, mem_we=0, mem_addr=BASE_ADDR, mem_din=0, busy=0, done=0, error=0, word_count=0 and checksum=0.
REQ-036 Reset asserted during LOAD SHALL abort the session; a write already scheduled for the next cycle SHALL be suppressed.

Verification
REQ-037 Scenario: pulse areset low mid-cycle -> all outputs take their REQ-035 values asynchronously; mem_addr=32'h00400020.
REQ-038 Scenario: start, then words 32'h20020001, 32'h8C010000 and 32'h AC020004 on consecutive cycles, with in_last on the third -> writes at 32'h00400020, 32'h00400024 and 32'h00400028; word_count=3; checksum=32'h58050005; done=1 together with the third mem_we pulse; busy=0 afterwards.
REQ-039 Scenario: the same three words with in_valid low for 2 cycles between each -> identical writes and checksum; no mem_we pulse during the gaps.
REQ-040 Scenario: MAX_WORDS=2, then three words with no in_last -> two writes only; error=1; word_count=2; no write at 32'h00400028.
REQ-041 Scenario: areset low after 2 words of a 4-word load, then a new start and 1 word with in_last -> a single write at 32'h00400020; word_count=1.
REQ-042 Scenario: start pulsed during LOAD -> no effect on word_count or mem_addr; start from DONE -> done clears, and the next write goes to 32'h00400020.
